instr_mem_responder: RTL and testbench

Responder end of the instruction-fetch req/grant/rvalid handshake, acting as the memory on the core's instruction port. It accepts fetch requests, grants them subject to an outstanding-request limit, and returns word data in order after a fixed read latency. It gives the IF pipeline stage and its tracker a deterministic, parameterised memory to fetch from in simulation and FPGA bring-up. An independent load port preloads program images.

---
 rtl/instr_mem_if.sv | 21 ++
 rtl/instr_mem_responder.sv | 99 +++++++++
 tb/tb_instr_mem_responder.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/instr_mem_if.sv
// Instruction-fetch req/grant/rvalid handshake between a core (master) and a memory responder (slave).
interface instr_mem_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) ();
  logic                  instr_req;
  logic [ADDR_WIDTH-1:0] instr_addr;
  logic                  instr_grant;
  logic                  instr_rvalid;
  logic [DATA_WIDTH-1:0] instr_rdata;

  modport master (
    output instr_req, instr_addr,
    input  instr_grant, instr_rvalid, instr_rdata
  );

  modport slave (
    input  instr_req, instr_addr,
    output instr_grant, instr_rvalid, instr_rdata
  );
endinterface

// File: rtl/instr_mem_responder.sv
// Fixed-latency, in-order instruction memory responder with an outstanding-request limit and a preload port.
// Optional grant stalling by an 8-bit LFSR is enabled with `define INSTR_RESP_STALL_EN.
module instr_mem_responder #(
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned MEM_DEPTH       = 1024,
  parameter int unsigned READ_LATENCY    = 1,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  instr_mem_if.slave            bus,
  input  logic                  load_we,
  input  logic [ADDR_WIDTH-1:0] load_addr,
  input  logic [DATA_WIDTH-1:0] load_wdata,
  output logic [2:0]            outstanding_o
);

  localparam int unsigned IDX_W = $clog2(MEM_DEPTH);

  logic [DATA_WIDTH-1:0]   mem [MEM_DEPTH];
  logic [IDX_W-1:0]        fetch_idx;
  logic [IDX_W-1:0]        load_idx;
  logic [DATA_WIDTH-1:0]   fetch_word;
  logic                    stall;
  logic                    grant;
  logic [READ_LATENCY-1:0] pipe_valid;
  logic [DATA_WIDTH-1:0]   pipe_data [READ_LATENCY];
  logic                    unused_addr_bits;

  assign fetch_idx  = bus.instr_addr[IDX_W+1:2];
  assign load_idx   = load_addr[IDX_W+1:2];
  assign fetch_word = mem[fetch_idx];

  assign unused_addr_bits = ^{bus.instr_addr[1:0], bus.instr_addr[ADDR_WIDTH-1:IDX_W+2],
                              load_addr[1:0], load_addr[ADDR_WIDTH-1:IDX_W+2]};

  // A response leaving the pipeline this cycle frees its slot for a same-cycle grant.
  assign grant = rst_n && bus.instr_req && !stall &&
                 ((outstanding_o - 3'(pipe_valid[READ_LATENCY-1])) < 3'(MAX_OUTSTANDING));

  assign bus.instr_grant  = grant;
  assign bus.instr_rvalid = pipe_valid[READ_LATENCY-1];
  assign bus.instr_rdata  = pipe_data[READ_LATENCY-1];

`ifdef INSTR_RESP_STALL_EN
  logic [7:0] lfsr;

  // Fibonacci LFSR, taps 8,6,5,4; grant is withheld while bit 0 is set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr <= 8'hA5;
    end else begin
      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end
  end

  assign stall = lfsr[0];
`else
  assign stall = 1'b0;
`endif

  // Storage is not reset so preloaded images survive a core reset.
  always_ff @(posedge clk) begin
    if (load_we) begin
      mem[load_idx] <= load_wdata;
    end
  end

  // Data only advances with its valid bit, so the last stage holds rdata between responses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_valid <= '0;
      for (int i = 0; i < READ_LATENCY; i++) begin
        pipe_data[i] <= '0;
      end
    end else begin
      pipe_valid[0] <= grant;
      if (grant) begin
        pipe_data[0] <= fetch_word;
      end
      for (int i = 1; i < READ_LATENCY; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        if (pipe_valid[i-1]) begin
          pipe_data[i] <= pipe_data[i-1];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outstanding_o <= 3'd0;
    end else begin
      outstanding_o <= outstanding_o + 3'(grant) - 3'(pipe_valid[READ_LATENCY-1]);
    end
  end

endmodule

// File: tb/tb_instr_mem_responder.sv
// Randomized bench for instr_mem_responder: two instances (latency 1 and 3) checked against a queue-based model.
module tb_instr_mem_responder;

  localparam int unsigned NDUT = 2;

  logic        clk;
  logic        rst_n;
  logic        load_we;
  logic [31:0] load_addr;
  logic [31:0] load_wdata;
  logic [2:0]  out0, out1;

  instr_mem_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus0 ();
  instr_mem_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus1 ();

  instr_mem_responder #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(1024),
                        .READ_LATENCY(1), .MAX_OUTSTANDING(2)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0.slave), .load_we(load_we),
    .load_addr(load_addr), .load_wdata(load_wdata), .outstanding_o(out0));

  instr_mem_responder #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(1024),
                        .READ_LATENCY(3), .MAX_OUTSTANDING(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1.slave), .load_we(load_we),
    .load_addr(load_addr), .load_wdata(load_wdata), .outstanding_o(out1));

  logic [NDUT-1:0] obs_grant, obs_rvalid;
  logic [31:0]     obs_rdata [NDUT];
  logic [2:0]      obs_out   [NDUT];

  assign obs_grant  = {bus1.instr_grant, bus0.instr_grant};
  assign obs_rvalid = {bus1.instr_rvalid, bus0.instr_rvalid};
  assign obs_rdata[0] = bus0.instr_rdata;
  assign obs_rdata[1] = bus1.instr_rdata;
  assign obs_out[0]   = out0;
  assign obs_out[1]   = out1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: per-instance FIFO of (word, due cycle) plus a flat memory image.
  int          lat [NDUT] = '{1, 3};
  int          lim [NDUT] = '{2, 2};
  logic [31:0] q_data [NDUT][8];
  int          q_due  [NDUT][8];
  int          q_head [NDUT];
  int          q_cnt  [NDUT];
  logic [31:0] exp_rdata [NDUT];
  logic [31:0] tb_mem [1024];
  logic [7:0]  m_lfsr;
  int          cyc;
  int          checks;
  int          failures;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h cyc=%0d", tag, got, exp, cyc);
    end
  endtask

  function automatic bit model_stall();
`ifdef INSTR_RESP_STALL_EN
    return m_lfsr[0];
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NDUT; k++) begin
      q_head[k]    = 0;
      q_cnt[k]     = 0;
      exp_rdata[k] = 32'h0;
    end
    m_lfsr = 8'hA5;
  endtask

  // One clock cycle: drive at the falling edge, check, then advance the model past the next rising edge.
  task automatic step(input bit req, input logic [31:0] addr, input bit we,
                      input logic [31:0] laddr, input logic [31:0] wdata);
    bit rv;
    bit g;
    @(negedge clk);
    rst_n           = 1'b1;
    bus0.instr_req  = req;
    bus0.instr_addr = addr;
    bus1.instr_req  = req;
    bus1.instr_addr = addr;
    load_we         = we;
    load_addr       = laddr;
    load_wdata      = wdata;
    #1;
    for (int k = 0; k < NDUT; k++) begin
      rv = (q_cnt[k] > 0) && (q_due[k][q_head[k]] == cyc);
      g  = req && !model_stall() && ((q_cnt[k] - int'(rv)) < lim[k]);
      check($sformatf("outstanding%0d", k), 32'(obs_out[k]), 32'(q_cnt[k]));
      check($sformatf("grant%0d", k), 32'(obs_grant[k]), 32'(g));
      check($sformatf("rvalid%0d", k), 32'(obs_rvalid[k]), 32'(rv));
      if (rv) begin
        exp_rdata[k] = q_data[k][q_head[k]];
        q_head[k]    = (q_head[k] + 1) % 8;
        q_cnt[k]--;
      end
      check($sformatf("rdata%0d", k), obs_rdata[k], exp_rdata[k]);
      if (g) begin
        q_data[k][(q_head[k] + q_cnt[k]) % 8] = tb_mem[addr[11:2]];
        q_due[k][(q_head[k] + q_cnt[k]) % 8]  = cyc + lat[k];
        q_cnt[k]++;
      end
    end
    if (we) tb_mem[laddr[11:2]] = wdata;
    m_lfsr = {m_lfsr[6:0], ^(m_lfsr & 8'hB8)};
    cyc++;
  endtask

  task automatic reset_cycle();
    @(negedge clk);
    rst_n          = 1'b0;
    bus0.instr_req = 1'b1;
    bus1.instr_req = 1'b1;
    load_we        = 1'b0;
    #1;
    for (int k = 0; k < NDUT; k++) begin
      check($sformatf("rst_grant%0d", k), 32'(obs_grant[k]), 32'h0);
      check($sformatf("rst_rvalid%0d", k), 32'(obs_rvalid[k]), 32'h0);
      check($sformatf("rst_rdata%0d", k), obs_rdata[k], 32'h0);
      check($sformatf("rst_out%0d", k), 32'(obs_out[k]), 32'h0);
    end
    model_reset();
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
  endtask

  function automatic logic [31:0] rand_addr(input int idx);
    return ($urandom() & ~32'h0000_0FFC) | (32'(idx) << 2);
  endfunction

  initial begin
    checks          = 0;
    failures        = 0;
    cyc             = 0;
    rst_n           = 1'b0;
    bus0.instr_req  = 1'b0;
    bus0.instr_addr = 32'h0;
    bus1.instr_req  = 1'b0;
    bus1.instr_addr = 32'h0;
    load_we         = 1'b0;
    load_addr       = 32'h0;
    load_wdata      = 32'h0;
    model_reset();
    reset_cycle();
    reset_cycle();

    // Preload words 0..31; word 0 and word 4 get known patterns.
    for (int i = 0; i < 32; i++) begin
      logic [31:0] w;
      w = (i == 0) ? 32'h1234_5678 : (i == 4) ? 32'hDEAD_BEEF : $urandom();
      step(1'b0, 32'h0, 1'b1, 32'(i) << 2, w);
    end

    // Single fetch of word 4.
    step(1'b1, 32'h10, 1'b0, 32'h0, 32'h0);
    step(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    if (!model_stall()) check("dir_beef", obs_rdata[0], 32'hDEAD_BEEF);
    idle(4);

    // Back-to-back fetches of consecutive words.
    for (int i = 0; i < 4; i++) step(1'b1, 32'(i) << 2, 1'b0, 32'h0, 32'h0);
    idle(5);

    // Address beyond MEM_DEPTH*4 wraps onto word 0.
    step(1'b1, 32'h1000, 1'b0, 32'h0, 32'h0);
    idle(4);
    check("dir_wrap", obs_rdata[1], 32'h1234_5678);

    // Held request against the outstanding limit.
    for (int i = 0; i < 10; i++) step(1'b1, 32'(i) << 2, 1'b0, 32'h0, 32'h0);
    idle(5);

    // Same-cycle load and fetch of one word returns the old contents.
    step(1'b1, 32'h20, 1'b1, 32'h20, 32'hCAFE_F00D);
    step(1'b1, 32'h20, 1'b0, 32'h0, 32'h0);
    idle(5);

    // Reset with requests in flight drops them.
    step(1'b1, 32'h0, 1'b0, 32'h0, 32'h0);
    step(1'b1, 32'h4, 1'b0, 32'h0, 32'h0);
    reset_cycle();
    idle(4);
    step(1'b1, 32'h10, 1'b0, 32'h0, 32'h0);
    idle(5);

    // Held request for 64 cycles (stall pattern when the LFSR is built in).
    for (int i = 0; i < 64; i++) step(1'b1, rand_addr(i % 32), 1'b0, 32'h0, 32'h0);
    idle(5);

    // Random traffic with loads colliding with fetches and an occasional reset.
    for (int i = 0; i < 1500; i++) begin
      if (i == 700) reset_cycle();
      step($urandom_range(0, 3) != 0, rand_addr($urandom_range(0, 31)),
           $urandom_range(0, 3) == 0, rand_addr($urandom_range(0, 31)), $urandom());
    end
    idle(6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
